// File: rtl/instr_fetch_unit.sv
// Instruction fetch: accepts PCs, reads a variable-latency instruction memory and
// buffers {pc, instr, fault} entries in a small in-order FIFO for decode.
module instr_fetch_unit #(
    parameter int ADDR_W     = 8,
    parameter int INSTR_W    = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               pc_valid,
    output logic               pc_ready,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               flush,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic               if_fault,
    output logic [1:0]         fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and the payload holds while valid=1 and ready=0.
    // rst_n is active-high: 1 means reset.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ADDR_W-1:0]  pc_q    [FIFO_DEPTH];
    logic [INSTR_W-1:0] instr_q [FIFO_DEPTH];
    logic               fault_q [FIFO_DEPTH];

    logic               accept;
    logic               misaligned;
    logic               push_mis;
    logic               push_mem;
    logic               push;
    logic               pop;
    logic [ADDR_W-1:0]  push_pc;
    logic [INSTR_W-1:0] push_instr;

    // Only IDLE accepts, and no request is outstanding there, so the entry count alone
    // guarantees a free slot for whatever this PC eventually pushes.
    assign pc_ready   = !rst_n && (state == IDLE) && (count < DEPTH_C) && !flush;
    assign accept     = pc_valid && pc_ready;
    assign misaligned = (pc_in[1:0] != 2'b00);
    assign push_mis   = accept && misaligned;
    assign push_mem   = !rst_n && (state == REQ) && mem_ack && !flush;
    assign push       = push_mis || push_mem;
    assign push_pc    = push_mis ? pc_in : mem_addr;
    assign push_instr = push_mis ? '0 : mem_rdata;
    assign pop        = if_valid && if_ready && !flush;

    assign fsm_state  = state;
    assign if_valid   = (count != '0);
    assign if_pc      = if_valid ? pc_q[rd_ptr]    : '0;
    assign if_instr   = if_valid ? instr_q[rd_ptr] : '0;
    assign if_fault   = if_valid ? fault_q[rd_ptr] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && !misaligned) begin
                        mem_addr <= pc_in;
                        mem_req  <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n || flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]    <= push_pc;
            instr_q[wr_ptr] <= push_instr;
            fault_q[wr_ptr] <= push_mis;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: hand-computed vectors checked with immediate assertions.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [7:0]  if_pc;
    logic [31:0] if_instr;
    logic        if_fault;
    logic [1:0]  fsm_state;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(8), .INSTR_W(32), .FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc_in     (pc_in),
        .pc_valid  (pc_valid),
        .pc_ready  (pc_ready),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .flush     (flush),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_pc     (if_pc),
        .if_instr  (if_instr),
        .if_fault  (if_fault),
        .fsm_state (fsm_state)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called after inputs for the current cycle are set; #1 lets combinational outputs settle.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1; pc_in = 8'h04; pc_valid = 1'b1; mem_ack = 1'b0;
        mem_rdata = 32'h0; flush = 1'b0; if_ready = 1'b0;

        // T1 reset with pc_valid held high
        next_cycle();
        next_cycle();
        #1;
        chk("t1_pc_ready_in_reset", 32'(pc_ready), 32'd0);
        chk("t1_mem_req",           32'(mem_req),  32'd0);
        chk("t1_mem_addr",          32'(mem_addr), 32'd0);
        chk("t1_if_valid",          32'(if_valid), 32'd0);
        chk("t1_if_pc",             32'(if_pc),    32'd0);
        chk("t1_if_instr",          if_instr,      32'd0);
        chk("t1_if_fault",          32'(if_fault), 32'd0);
        chk("t1_state",             32'(fsm_state), 32'd0);
        rst_n = 1'b0; pc_valid = 1'b0;
        #1;
        chk("t1_pc_ready_after", 32'(pc_ready), 32'd1);

        // T2 single fetch, ack one cycle after mem_req rises
        pc_in = 8'h04; pc_valid = 1'b1;
        next_cycle();
        pc_valid = 1'b0;
        #1;
        chk("t2_mem_req",  32'(mem_req),  32'd1);
        chk("t2_mem_addr", 32'(mem_addr), 32'h04);
        chk("t2_pc_ready", 32'(pc_ready), 32'd0);
        next_cycle();
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("t2_no_bypass", 32'(if_valid), 32'd0);
        next_cycle();
        mem_ack = 1'b0;
        #1;
        chk("t2_if_valid",  32'(if_valid), 32'd1);
        chk("t2_if_pc",     32'(if_pc),    32'h04);
        chk("t2_if_instr",  if_instr,      32'hDEADBEEF);
        chk("t2_if_fault",  32'(if_fault), 32'd0);
        chk("t2_req_drop",  32'(mem_req),  32'd0);
        if_ready = 1'b1;
        next_cycle();
        if_ready = 1'b0;
        #1;
        chk("t2_popped", 32'(if_valid), 32'd0);

        // T3 back-pressure with 0x00, 0x04, 0x08
        pc_in = 8'h00; pc_valid = 1'b1;
        next_cycle();
        pc_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h11110000;
        next_cycle();
        mem_ack = 1'b0; pc_in = 8'h04; pc_valid = 1'b1;
        #1;
        chk("t3_ready_one_entry", 32'(pc_ready), 32'd1);
        next_cycle();
        pc_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h22220004;
        next_cycle();
        mem_ack = 1'b0; pc_in = 8'h08; pc_valid = 1'b1;
        #1;
        chk("t3_stalled",    32'(pc_ready), 32'd0);
        chk("t3_head_pc0",   32'(if_pc),    32'h00);
        next_cycle();
        #1;
        chk("t3_still_stall", 32'(pc_ready), 32'd0);
        chk("t3_no_req",      32'(mem_req),  32'd0);
        chk("t3_hold_pc0",    32'(if_pc),    32'h00);
        if_ready = 1'b1;
        #1;
        chk("t3_out0_instr", if_instr, 32'h11110000);
        next_cycle();
        #1;
        chk("t3_accept_pc8", 32'(pc_ready), 32'd1);
        chk("t3_out1_pc",    32'(if_pc),    32'h04);
        chk("t3_out1_instr", if_instr,      32'h22220004);
        next_cycle();
        pc_valid = 1'b0;
        #1;
        chk("t3_empty_mid", 32'(if_valid), 32'd0);
        chk("t3_req_pc8",   32'(mem_addr), 32'h08);
        mem_ack = 1'b1; mem_rdata = 32'h33330008;
        next_cycle();
        mem_ack = 1'b0;
        #1;
        chk("t3_out2_pc",    32'(if_pc),    32'h08);
        chk("t3_out2_instr", if_instr,      32'h33330008);
        next_cycle();
        if_ready = 1'b0;
        #1;
        chk("t3_drained", 32'(if_valid), 32'd0);

        // T4 flush in the first REQ cycle, ack arrives 3 cycles after mem_req rises
        pc_in = 8'h10; pc_valid = 1'b1;
        next_cycle();
        pc_valid = 1'b0; flush = 1'b1;
        #1;
        chk("t4_req", 32'(mem_req), 32'd1);
        next_cycle();
        flush = 1'b0;
        #1;
        chk("t4_drain_state", 32'(fsm_state), 32'd2);
        chk("t4_drain_req",   32'(mem_req),   32'd1);
        chk("t4_drain_ready", 32'(pc_ready),  32'd0);
        next_cycle();
        next_cycle();
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        next_cycle();
        mem_ack = 1'b0;
        #1;
        chk("t4_idle",       32'(fsm_state), 32'd0);
        chk("t4_req_low",    32'(mem_req),   32'd0);
        chk("t4_discarded",  32'(if_valid),  32'd0);
        pc_in = 8'h20; pc_valid = 1'b1;
        next_cycle();
        pc_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h20202020;
        #1;
        chk("t4_addr20", 32'(mem_addr), 32'h20);
        next_cycle();
        mem_ack = 1'b0;
        #1;
        chk("t4_pc20",    32'(if_pc), 32'h20);
        chk("t4_instr20", if_instr,   32'h20202020);
        if_ready = 1'b1;
        next_cycle();
        if_ready = 1'b0;

        // T5 misaligned PC faults without touching memory
        pc_in = 8'h06; pc_valid = 1'b1;
        #1;
        chk("t5_ready", 32'(pc_ready), 32'd1);
        next_cycle();
        pc_valid = 1'b0;
        #1;
        chk("t5_no_req",  32'(mem_req),   32'd0);
        chk("t5_valid",   32'(if_valid),  32'd1);
        chk("t5_fault",   32'(if_fault),  32'd1);
        chk("t5_pc",      32'(if_pc),     32'h06);
        chk("t5_instr",   if_instr,       32'd0);
        chk("t5_state",   32'(fsm_state), 32'd0);
        if_ready = 1'b1;
        next_cycle();
        if_ready = 1'b0;

        // T6 pop and mem_ack in the same cycle with the slots fully committed
        pc_in = 8'h40; pc_valid = 1'b1;
        next_cycle();
        pc_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hAAAA0040;
        next_cycle();
        mem_ack = 1'b0; pc_in = 8'h44; pc_valid = 1'b1;
        next_cycle();
        pc_valid = 1'b0; if_ready = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hBBBB0044;
        #1;
        chk("t6_head40", if_instr, 32'hAAAA0040);
        next_cycle();
        if_ready = 1'b0; mem_ack = 1'b0;
        #1;
        chk("t6_head44_pc",    32'(if_pc),    32'h44);
        chk("t6_head44_instr", if_instr,      32'hBBBB0044);
        chk("t6_one_entry",    32'(pc_ready), 32'd1);
        pc_in = 8'h48; pc_valid = 1'b1;
        next_cycle();
        pc_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCCCC0048;
        next_cycle();
        mem_ack = 1'b0;
        #1;
        chk("t6_full",     32'(pc_ready), 32'd0);
        chk("t6_still44",  32'(if_pc),    32'h44);
        if_ready = 1'b1;
        next_cycle();
        #1;
        chk("t6_then48",   if_instr, 32'hCCCC0048);
        next_cycle();
        if_ready = 1'b0;
        #1;
        chk("t6_empty", 32'(if_valid), 32'd0);

        // Top-of-range PC, then flush of a non-empty FIFO while idle
        pc_in = 8'hFC; pc_valid = 1'b1;
        next_cycle();
        pc_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000FCFC;
        #1;
        chk("wrap_addr", 32'(mem_addr), 32'hFC);
        next_cycle();
        mem_ack = 1'b0;
        #1;
        chk("wrap_pc", 32'(if_pc), 32'hFC);
        flush = 1'b1; if_ready = 1'b1; pc_in = 8'h30; pc_valid = 1'b1;
        #1;
        chk("flush_no_accept", 32'(pc_ready), 32'd0);
        next_cycle();
        flush = 1'b0; if_ready = 1'b0; pc_valid = 1'b0;
        #1;
        chk("flush_empty",  32'(if_valid), 32'd0);
        chk("flush_no_req", 32'(mem_req),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
